dcache_line_memory: RTL and testbench

//   Data-memory responder on the 256-bit line interface driven by the data cache

---
 rtl/dcache_line_memory.sv | 122 ++++++++++++
 tb/tb_dcache_line_memory.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_memory.sv
// Line-addressed backing store for the data cache: fixed-latency read/write responder
// with a single-cycle ack, a mandatory turnaround cycle and completed-request counters.
module dcache_line_memory #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [7:0]  LAST_CNT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StTurn} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [31:0]         rd_cnt_q, rd_cnt_d;
    logic [31:0]         wr_cnt_q, wr_cnt_d;
    logic                mem_we;

    logic [LINE_W-1:0]   mem [DEPTH];

    // Offset bits and tag bits above the index simply alias.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+5], addr_i[4:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    wr_d    = write_i;
                    idx_d   = addr_i[ADDR_W+4:5];
                    wdata_d = data_i;
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = StAck;
                    // Read data is registered on entry to ACK so it is stable for the whole ack.
                    if (!wr_q) rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StAck: begin
                state_d = StTurn;
                if (wr_q) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                end
            end
            StTurn: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage is never cleared; reset only suppresses a write still in flight.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack_o      = (state_q == StAck);
    assign busy_o     = (state_q != StIdle);
    assign data_o     = rdata_q;
    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;

endmodule

// File: tb/tb_dcache_line_memory.sv
// Directed bench for dcache_line_memory: latency, read/write data, back-to-back handshake,
// aliasing, abort and reset-in-flight.
module tb_dcache_line_memory;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         write;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack;
    logic [255:0] rdata;
    logic         busy;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    int checks   = 0;
    int failures = 0;
    int ack_total = 0;
    int lat;
    int acks_before;
    logic [255:0] got;

    localparam logic [255:0] DEAD  = {8{32'hDEADBEEF}};
    localparam logic [255:0] VAL_A = {8{32'h0A0A5555}};
    localparam logic [255:0] VAL_B = {8{32'hB0B0CCCC}};

    dcache_line_memory dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .write_i    (write),
        .addr_i     (addr),
        .data_i     (wdata),
        .ack_o      (ack),
        .data_o     (rdata),
        .busy_o     (busy),
        .rd_count_o (rd_count),
        .wr_count_o (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (ack) ack_total <= ack_total + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until ack is seen; returns the number of edges taken, or -1 on timeout.
    task automatic wait_ack(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (ack) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Full request: accept, wait for ack, capture data_o, drop enable, pass TURN back to IDLE.
    task automatic xact(input logic wr, input logic [31:0] a, input logic [255:0] d,
                        output int cyc, output logic [255:0] rd);
        enable = 1'b1;
        write  = wr;
        addr   = a;
        wdata  = d;
        tick();
        wait_ack(20, cyc);
        rd = rdata;
        enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; write = 1'b0; addr = 32'h0; wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ack", {255'd0, ack}, 256'd0);
        check("reset_busy", {255'd0, busy}, 256'd0);
        check("reset_data", rdata, 256'd0);
        check("reset_rd_count", {224'd0, rd_count}, 256'd0);
        check("reset_wr_count", {224'd0, wr_count}, 256'd0);

        // 1: read idx 3, enable held through ack+1
        enable = 1'b1; write = 1'b0; addr = 32'h60;
        tick();
        check("t1_busy_after_accept", {255'd0, busy}, 256'd1);
        wait_ack(20, lat);
        check("t1_latency", 256'(lat), 256'd10);
        tick();
        check("t1_ack_one_cycle", {255'd0, ack}, 256'd0);
        check("t1_busy_turn", {255'd0, busy}, 256'd1);
        check("t1_rd_count", {224'd0, rd_count}, 256'd1);
        enable = 1'b0;
        tick();
        check("t1_idle", {255'd0, busy}, 256'd0);
        tick();
        check("t1_ack_total", 256'(ack_total), 256'd1);

        // 2: write then read idx 7
        xact(1'b1, 32'hE0, DEAD, lat, got);
        check("t2_wr_latency", 256'(lat), 256'd10);
        check("t2_wr_count", {224'd0, wr_count}, 256'd1);
        xact(1'b0, 32'hE0, '0, lat, got);
        check("t2_rd_data", got, DEAD);
        check("t2_rd_count", {224'd0, rd_count}, 256'd2);

        // 3: writeback followed by read with enable held high
        acks_before = ack_total;
        enable = 1'b1; write = 1'b1; addr = 32'h400; wdata = VAL_A;
        tick();
        wait_ack(20, lat);
        check("t3_wr_latency", 256'(lat), 256'd10);
        write = 1'b0; addr = 32'h20;
        tick();
        check("t3_turn_no_ack", {255'd0, ack}, 256'd0);
        check("t3_data_held", rdata, DEAD);
        tick();
        check("t3_idle_after_turn", {255'd0, busy}, 256'd0);
        tick();
        check("t3_read_accepted", {255'd0, busy}, 256'd1);
        wait_ack(20, lat);
        check("t3_rd_latency", 256'(lat), 256'd10);
        enable = 1'b0;
        tick();
        tick();
        check("t3_two_acks", 256'(ack_total - acks_before), 256'd2);
        check("t3_wr_count", {224'd0, wr_count}, 256'd2);
        check("t3_rd_count", {224'd0, rd_count}, 256'd3);

        // 4: aliasing, addr 0x4000 maps to idx 0
        xact(1'b1, 32'h4000, 256'd1, lat, got);
        xact(1'b0, 32'h0, '0, lat, got);
        check("t4_alias_data", got, 256'd1);

        // 5: abort in WAIT
        acks_before = ack_total;
        enable = 1'b1; write = 1'b0; addr = 32'h60;
        tick();
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("t5_abort_busy", {255'd0, busy}, 256'd0);
        for (int i = 0; i < 14; i++) tick();
        check("t5_no_ack", 256'(ack_total - acks_before), 256'd0);
        check("t5_rd_count", {224'd0, rd_count}, 256'd4);

        // 6: reset during WAIT of a write to idx 2
        xact(1'b1, 32'h40, VAL_A, lat, got);
        acks_before = ack_total;
        enable = 1'b1; write = 1'b1; addr = 32'h40; wdata = VAL_B;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        check("t6_busy_after_reset", {255'd0, busy}, 256'd0);
        check("t6_rd_count_cleared", {224'd0, rd_count}, 256'd0);
        check("t6_wr_count_cleared", {224'd0, wr_count}, 256'd0);
        for (int i = 0; i < 14; i++) tick();
        check("t6_no_ack", 256'(ack_total - acks_before), 256'd0);
        xact(1'b0, 32'h40, '0, lat, got);
        check("t6_old_data", got, VAL_A);
        check("t6_rd_count", {224'd0, rd_count}, 256'd1);
        check("t6_wr_count", {224'd0, wr_count}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
